uart_tx_fifo: RTL

Transmit-side byte buffer that sits directly upstream of the UART transmitter. It accepts bytes from a producer via a valid/ready handshake and stores up to DEPTH entries. It presents them one at a time to the transmitter using the transmitter's tx_byte_valid / tx_active / tx_done protocol, so the producer can burst data without tracking frame timing.

---
 rtl/uart_tx_fifo.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte buffer feeding a UART transmitter.
// Bytes are pushed via wr_valid/wr_ready. They are handed to the transmitter one at a
// time through the tx_byte_valid / tx_active / tx_done protocol.
module uart_tx_fifo #(
    parameter int unsigned PACK_SIZE = 8,
    parameter int unsigned DEPTH     = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_valid,
    input  logic [PACK_SIZE-1:0]         wr_data,
    output logic                         wr_ready,
    input  logic                         flush,
    output logic                         tx_byte_valid,
    output logic [PACK_SIZE-1:0]         tx_byte_data,
    input  logic                         tx_active,
    input  logic                         tx_done,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWaitDone
    } state_e;

    logic [PACK_SIZE-1:0] mem [DEPTH];

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    state_e               state_q, state_d;
    logic                 valid_q, valid_d;
    logic [PACK_SIZE-1:0] data_q, data_d;
    logic                 overflow_q, overflow_d;
    logic                 push, pop;

    // Status flags come from the registered count only, never from the pointers.
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign wr_ready = ~full;
    assign count    = count_q;

    assign tx_byte_valid = valid_q;
    assign tx_byte_data  = data_q;
    assign overflow      = overflow_q;

    // flush wins over a same-cycle push; a full FIFO rejects even if a pop coincides.
    assign push = wr_valid & ~full & ~flush;

    // Handoff FSM: load head byte, hold the request until tx_active, then wait for tx_done.
    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        data_d  = data_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty && !flush) begin
                    data_d  = mem[rd_ptr_q];
                    valid_d = 1'b1;
                    state_d = StReq;
                end
            end
            StReq: begin
                if (flush) begin
                    // The transmitter never took this byte; drop it with the rest.
                    valid_d = 1'b0;
                    state_d = StIdle;
                end else if (tx_active) begin
                    valid_d = 1'b0;
                    pop     = 1'b1;
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                // The in-flight frame always completes, flush or not.
                if (tx_done) begin
                    state_d = StIdle;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = wr_valid & full & ~flush;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State, pointers, count and handoff registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            valid_q    <= 1'b0;
            data_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

endmodule
